// File: rtl/algebra_pkg.sv
// Shared widths and operand/result types for the algebra (y = a*x + b) pipeline.
package algebra_pkg;

    localparam int ALG_W  = 4;
    localparam int ALG_YW = 2 * ALG_W + 1;

    typedef logic signed [ALG_W-1:0]  operand_t;
    typedef logic signed [ALG_YW-1:0] result_t;

endpackage

// File: rtl/algebra_mul.sv
// Stage-1 registered signed multiplier: p = a*x, held while en is low.
module algebra_mul #(
    parameter int W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   x,
    output logic signed [2*W-1:0] p
);

    logic signed [2*W-1:0] p_d, p_q;

    // Sign-extend before multiplying so -8*-8 = 64 is exact in 2W bits.
    always_comb begin
        p_d = p_q;
        if (en) begin
            p_d = (2 * W)'(a) * (2 * W)'(x);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/algebra.sv
// Two-stage signed y = a*x + b pipeline; define ALGEBRA_INREG_EN to add an
// input register stage (latency 3 instead of 2).
module algebra
    import algebra_pkg::*;
#(
    parameter int  W  = ALG_W,
    localparam int YW = 2 * W + 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    input  logic signed [W-1:0]  a,
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  b,
    output logic signed [YW-1:0] y,
    output logic                 out_valid
);

    logic signed [W-1:0] a0, x0, b0;
    logic                v0;

`ifdef ALGEBRA_INREG_EN
    logic signed [W-1:0] a0_q, x0_q, b0_q;
    logic                v0_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            a0_q <= '0;
            x0_q <= '0;
            b0_q <= '0;
            v0_q <= 1'b0;
        end else begin
            v0_q <= in_valid;
            if (in_valid) begin
                a0_q <= a;
                x0_q <= x;
                b0_q <= b;
            end
        end
    end

    assign a0 = a0_q;
    assign x0 = x0_q;
    assign b0 = b0_q;
    assign v0 = v0_q;
`else
    assign a0 = a;
    assign x0 = x;
    assign b0 = b;
    assign v0 = in_valid;
`endif

    // Stage 1: product, sign-extended offset and valid.
    logic signed [2*W-1:0] p1;
    logic signed [YW-1:0]  b1_q;
    logic                  v1_q;

    algebra_mul #(
        .W (W)
    ) u_mul (
        .clk (CLK),
        .rst (RST),
        .en  (v0),
        .a   (a0),
        .x   (x0),
        .p   (p1)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            b1_q <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= v0;
            if (v0) begin
                b1_q <= YW'(b0);
            end
        end
    end

    // Stage 2: sum into the result register; y holds across invalid cycles.
    logic signed [YW-1:0] sum;
    logic signed [YW-1:0] y_q;
    logic                 ov_q;

    assign sum = YW'(p1) + b1_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            y_q  <= '0;
            ov_q <= 1'b0;
        end else begin
            ov_q <= v1_q;
            if (v1_q) begin
                y_q <= sum;
            end
        end
    end

    assign y         = y_q;
    assign out_valid = ov_q;

endmodule

// File: tb/tb_algebra.sv
// Self-checking bench for algebra: directed cases plus randomized traffic
// against a latency-queue model of y = a*x + b.
module tb_algebra;
    import algebra_pkg::*;

`ifdef ALGEBRA_INREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic     CLK = 1'b0;
    logic     RST = 1'b1;
    logic     in_valid = 1'b0;
    operand_t a = '0, x = '0, b = '0;
    result_t  y;
    logic     out_valid;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        bit v;
        int val;
    } ent_t;

    ent_t pipe[$];
    int   exp_y = 0;
    bit   exp_v = 1'b0;

    algebra dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .a         (a),
        .x         (x),
        .b         (b),
        .y         (y),
        .out_valid (out_valid)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle, then advance the model: a result emerges LAT edges
    // after it is sampled, and y keeps the last valid result.
    task automatic tick(input bit r, input bit v, input int ai, input int xi, input int bi);
        ent_t e, o;
        RST      = r;
        in_valid = v;
        a        = operand_t'(ai);
        x        = operand_t'(xi);
        b        = operand_t'(bi);
        @(posedge CLK);
        #1;
        if (r) begin
            pipe.delete();
            exp_y = 0;
            exp_v = 1'b0;
        end else begin
            e.v   = v;
            e.val = ai * xi + bi;
            pipe.push_back(e);
            exp_v = 1'b0;
            if (pipe.size() == LAT) begin
                o     = pipe.pop_front();
                exp_v = o.v;
                if (o.v) exp_y = o.val;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 3, 2, -4);
            nvec++;
            if (y !== '0 || out_valid !== 1'b0) begin
                nerr++;
                $display("FAIL reset[%0d]: y=%0d ov=%b, want y=0 ov=0", i, y, out_valid);
            end
        end
        for (int i = 0; i < LAT; i++) tick(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_basic();
        tick(1'b0, 1'b1, 3, 2, -4);
        for (int i = 0; i < LAT - 1; i++) begin
            nvec++;
            if (out_valid !== 1'b0) begin
                nerr++;
                $display("FAIL basic_early[%0d]: ov=%b, want 0", i, out_valid);
            end
            tick(1'b0, 1'b0, 0, 0, 0);
        end
        nvec++;
        if (y !== 9'h002 || out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL basic: y=%h ov=%b, want y=002 ov=1", y, out_valid);
        end
        tick(1'b0, 1'b0, 0, 0, 0);
        nvec++;
        if (out_valid !== 1'b0 || y !== 9'h002) begin
            nerr++;
            $display("FAIL basic_hold: y=%h ov=%b, want y=002 ov=0", y, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int seen[$];
        int want[3] = '{11, -22, 17};
        int xs[3]   = '{5, -6, 7};
        for (int i = 0; i < 3 + LAT; i++) begin
            if (i < 3) tick(1'b0, 1'b1, 3, xs[i], -4);
            else       tick(1'b0, 1'b0, 0, 0, 0);
            if (out_valid === 1'b1) seen.push_back(int'(y));
            nvec++;
            if (y !== result_t'(exp_y) || out_valid !== exp_v) begin
                nerr++;
                $display("FAIL b2b[%0d]: y=%0d ov=%b, want y=%0d ov=%b",
                         i, y, out_valid, exp_y, exp_v);
            end
        end
        nvec++;
        if (seen.size() != 3 || seen[0] != want[0] || seen[1] != want[1] || seen[2] != want[2]) begin
            nerr++;
            $display("FAIL b2b_seq: got %p, want %p", seen, want);
        end
    endtask

    task automatic test_extremes();
        tick(1'b0, 1'b1, -8, -8, 7);
        tick(1'b0, 1'b1, -8, 7, -8);
        for (int i = 0; i < LAT - 2; i++) tick(1'b0, 1'b0, 0, 0, 0);
        nvec++;
        if (y !== 9'd71 || out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL extreme_pos: y=%0d ov=%b, want y=71 ov=1", y, out_valid);
        end
        tick(1'b0, 1'b0, 0, 0, 0);
        nvec++;
        if (y !== 9'h1C0 || out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL extreme_neg: y=%h ov=%b, want y=1c0 ov=1", y, out_valid);
        end
        tick(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_gap();
        logic    ov[LAT + 2];
        result_t yv[LAT + 2];
        tick(1'b0, 1'b1, 2, 3, 1);
        ov[0] = out_valid; yv[0] = y;
        tick(1'b0, 1'b0, 7, 7, 7);
        ov[1] = out_valid; yv[1] = y;
        tick(1'b0, 1'b1, -1, 5, 0);
        ov[2] = out_valid; yv[2] = y;
        for (int i = 3; i < LAT + 2; i++) begin
            tick(1'b0, 1'b0, 0, 0, 0);
            ov[i] = out_valid; yv[i] = y;
        end
        nvec++;
        if (ov[LAT-1] !== 1'b1 || ov[LAT] !== 1'b0 || ov[LAT+1] !== 1'b1) begin
            nerr++;
            $display("FAIL gap_ov: got %b%b%b, want 101", ov[LAT-1], ov[LAT], ov[LAT+1]);
        end
        nvec++;
        if (yv[LAT-1] !== 9'd7 || yv[LAT] !== 9'd7 || yv[LAT+1] !== -9'sd5) begin
            nerr++;
            $display("FAIL gap_y: got %0d,%0d,%0d, want 7,7,-5",
                     yv[LAT-1], yv[LAT], yv[LAT+1]);
        end
    endtask

    task automatic test_reset_flight();
        tick(1'b0, 1'b1, 3, 2, -4);
        tick(1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < LAT + 1; i++) begin
            tick(1'b0, 1'b0, 0, 0, 0);
            nvec++;
            if (out_valid !== 1'b0 || y !== '0) begin
                nerr++;
                $display("FAIL flight_flush[%0d]: y=%0d ov=%b, want y=0 ov=0", i, y, out_valid);
            end
        end
        tick(1'b0, 1'b1, 3, 5, -4);
        for (int i = 0; i < LAT - 1; i++) tick(1'b0, 1'b0, 0, 0, 0);
        nvec++;
        if (y !== 9'd11 || out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL flight_after: y=%0d ov=%b, want y=11 ov=1", y, out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit r  = ($urandom_range(0, 31) == 0);
            bit v  = ($urandom_range(0, 3) != 0);
            int ai = int'($urandom_range(0, 15)) - 8;
            int xi = int'($urandom_range(0, 15)) - 8;
            int bi = int'($urandom_range(0, 15)) - 8;
            tick(r, v, ai, xi, bi);
            nvec++;
            if (y !== result_t'(exp_y) || out_valid !== exp_v) begin
                nerr++;
                $display("FAIL random[%0d]: y=%0d ov=%b, want y=%0d ov=%b",
                         i, y, out_valid, exp_y, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_extremes();
        test_gap();
        test_reset_flight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/algebra.md
ALGEBRA -- requirements
Module: algebra

Interface
REQ-001 Parameter W, default 4: operand width in bits; two's-complement signed operands.
REQ-002 Parameter YW, default 2*W+1 (9): result width; SHALL NOT be overridden independently of W.
REQ-003 CLK  input  1  rising-edge clock; the block's only clock.
REQ-004 RST  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 in_valid  input  1  qualifies a, x and b in the current cycle.
REQ-006 a  input  W  signed coefficient.
REQ-007 x  input  W  signed variable.
REQ-008 b  input  W  signed offset.
REQ-009 y  output  YW  signed result a*x+b, registered.
REQ-010 out_valid  output  1  marks a cycle in which y holds a new result.

Function
REQ-011 The block SHALL compute y = a*x + b with all operands sign-extended to YW bits; no truncation, saturation or overflow is possible (range -64..71 at W=4).
REQ-012 Stage 1 SHALL register the product p = a*x (2W bits, signed) and the sign-extended b.
REQ-013 Stage 2 SHALL register y = p + b and out_valid.
REQ-014 Latency SHALL be 2 rising edges from in_valid=1 to out_valid=1; throughput one result per cycle, no back-pressure.
REQ-015 in_valid SHALL be carried through the pipeline, so out_valid equals in_valid delayed by 2 cycles.
REQ-016 When in_valid=0, the stage-1 data registers SHALL hold their values, and y SHALL hold its last value.
REQ-017 Operands that change on the same edge on which they are sampled SHALL be captured with their pre-edge values.
REQ-018 Most-negative operands (-8) SHALL be handled exactly: (-8)*(-8)+7 = 71 and (-8)*7+(-8) = -64.

Reset
REQ-019 While RST=1 at a rising edge, all pipeline registers, y and out_valid SHALL be cleared to 0.
REQ-020 Reset SHALL take priority over in_valid; data in flight when reset is asserted SHALL be discarded and SHALL NOT produce out_valid.
REQ-021 The first in_valid sampled after RST deasserts SHALL produce out_valid 2 cycles later.

Configuration
REQ-022 Macro ALGEBRA_INREG_EN, when defined, SHALL add an input register stage for a, x, b and in_valid, so latency becomes 3 cycles; that stage is also cleared by RST.
REQ-023 Without ALGEBRA_INREG_EN, latency SHALL be exactly 2 cycles, and all other behaviour SHALL be identical.

Structure
REQ-024 Package algebra_pkg SHALL hold the default W and YW values and the operand and result typedefs: signed logic [W-1:0] and signed logic [YW-1:0].
REQ-025 A sub-module algebra_mul SHALL implement the registered signed multiply of stage 1; the adder stage SHALL reside in algebra.

Verification
REQ-026 a=3, b=-4, x=2 with in_valid=1 -> y=2 (9'h002) and out_valid=1 two cycles later.
REQ-027 a=3, b=-4, x=5 -> y=11; then x=-6 -> y=-22 (9'h1EA); then x=7 -> y=17; issued on consecutive cycles, the results appear on consecutive cycles.
REQ-028 Extremes: a=-8, x=-8, b=7 -> y=71; a=-8, x=7, b=-8 -> y=-64 (9'h1C0).
REQ-029 Valid gap: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 delayed 2 cycles, with y held during the gap.
REQ-030 RST asserted one cycle after in_valid=1 -> no out_valid, y=0; the next input after reset releases yields the correct result.
REQ-031 With ALGEBRA_INREG_EN defined, REQ-026 stimulus -> y=2 after 3 cycles.
